// File: rtl/crc8_frame_sequencer.sv
// Frame sequencer around an external two-cycle CRC-8 engine: forwards input bytes,
// then appends the CRC (generate mode) or reports a zero-residue check (check mode).
module crc8_frame_sequencer #(
    parameter int LEN_WIDTH = 8,
    parameter int MAX_LEN   = 255
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 mode,
    input  logic [7:0]           in_data,
    input  logic                 in_valid,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic [7:0]           out_data,
    output logic                 out_valid,
    output logic                 out_last,
    input  logic                 out_ready,
    output logic [7:0]           crc_data,
    output logic                 crc_calculate,
    output logic                 crc_clear,
    input  logic [7:0]           crc_value,
    output logic                 frame_done,
    output logic                 crc_ok,
    output logic                 len_err,
    output logic [LEN_WIDTH-1:0] frame_len
);

    typedef enum logic [2:0] {
        CLR      = 3'd0,
        CLR_WAIT = 3'd1,
        WAIT_IN  = 3'd2,
        CALC     = 3'd3,
        BUSY     = 3'd4,
        EMIT     = 3'd5,
        APPEND   = 3'd6,
        STATUS   = 3'd7
    } state_e;

    localparam logic [LEN_WIDTH-1:0] MAX_LEN_C = LEN_WIDTH'(MAX_LEN);
    localparam logic [LEN_WIDTH-1:0] ONE_C     = LEN_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0] ZERO_C    = {LEN_WIDTH{1'b0}};

    state_e               state_q, state_d;
    logic [7:0]           data_q, data_d;
    logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
    logic                 mode_q, mode_d;
    logic                 last_q, last_d;
    logic                 len_err_next_q, len_err_next_d;
    logic                 crc_ok_q, crc_ok_d;
    logic                 len_err_q, len_err_d;
    logic [LEN_WIDTH-1:0] frame_len_q, frame_len_d;
    logic [LEN_WIDTH-1:0] cnt_inc_s;
    logic                 at_max_s;
    logic                 enter_status_s;

    // Next-state logic; frame results are captured on entry to STATUS so they
    // are already valid while frame_done is high.
    always_comb begin
        state_d        = state_q;
        data_d         = data_q;
        cnt_d          = cnt_q;
        mode_d         = mode_q;
        last_d         = last_q;
        len_err_next_d = len_err_next_q;
        enter_status_s = 1'b0;
        cnt_inc_s      = cnt_q + ONE_C;
        at_max_s       = (cnt_inc_s == MAX_LEN_C);

        case (state_q)
            CLR:      state_d = CLR_WAIT;
            CLR_WAIT: state_d = WAIT_IN;
            WAIT_IN: begin
                if (in_valid) begin
                    data_d         = in_data;
                    cnt_d          = cnt_inc_s;
                    last_d         = in_last | at_max_s;
                    len_err_next_d = ~in_last & at_max_s;
                    state_d        = CALC;
                    if (cnt_q == ZERO_C) begin
                        mode_d = mode;
                    end else begin
                        mode_d = mode_q;
                    end
                end else begin
                    state_d = WAIT_IN;
                end
            end
            CALC:     state_d = BUSY;
            BUSY:     state_d = EMIT;
            EMIT: begin
                if (out_ready) begin
                    if (!last_q) begin
                        state_d = WAIT_IN;
                    end else if (!mode_q) begin
                        state_d = APPEND;
                    end else begin
                        state_d        = STATUS;
                        enter_status_s = 1'b1;
                    end
                end else begin
                    state_d = EMIT;
                end
            end
            APPEND: begin
                if (out_ready) begin
                    state_d        = STATUS;
                    enter_status_s = 1'b1;
                end else begin
                    state_d = APPEND;
                end
            end
            STATUS: begin
                cnt_d   = ZERO_C;
                state_d = CLR;
            end
            default:  state_d = CLR;
        endcase

        if (enter_status_s) begin
            crc_ok_d    = mode_q ? (crc_value == 8'h00) : 1'b1;
            len_err_d   = len_err_next_q;
            frame_len_d = cnt_q;
        end else begin
            crc_ok_d    = crc_ok_q;
            len_err_d   = len_err_q;
            frame_len_d = frame_len_q;
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q        <= CLR;
            data_q         <= 8'h00;
            cnt_q          <= ZERO_C;
            mode_q         <= 1'b0;
            last_q         <= 1'b0;
            len_err_next_q <= 1'b0;
            crc_ok_q       <= 1'b0;
            len_err_q      <= 1'b0;
            frame_len_q    <= ZERO_C;
        end else begin
            state_q        <= state_d;
            data_q         <= data_d;
            cnt_q          <= cnt_d;
            mode_q         <= mode_d;
            last_q         <= last_d;
            len_err_next_q <= len_err_next_d;
            crc_ok_q       <= crc_ok_d;
            len_err_q      <= len_err_d;
            frame_len_q    <= frame_len_d;
        end
    end

    // Output decode from the registered state.
    always_comb begin
        in_ready      = 1'b0;
        out_valid     = 1'b0;
        out_last      = 1'b0;
        out_data      = 8'h00;
        crc_calculate = 1'b0;
        crc_clear     = 1'b0;
        frame_done    = 1'b0;
        case (state_q)
            CLR:     crc_clear = 1'b1;
            WAIT_IN: in_ready = 1'b1;
            CALC:    crc_calculate = 1'b1;
            EMIT: begin
                out_valid = 1'b1;
                out_data  = data_q;
                out_last  = last_q & mode_q;
            end
            APPEND: begin
                out_valid = 1'b1;
                out_data  = crc_value;
                out_last  = 1'b1;
            end
            STATUS:  frame_done = 1'b1;
            default: in_ready = 1'b0;
        endcase
    end

    assign crc_data  = data_q;
    assign crc_ok    = crc_ok_q;
    assign len_err   = len_err_q;
    assign frame_len = frame_len_q;

endmodule

// File: tb/tb_crc8_frame_sequencer.sv
// Bench for crc8_frame_sequencer: two instances (MAX_LEN 255 and 4), each with a
// behavioural two-cycle CRC-8 engine, and a queue scoreboard of output bytes and status.
module tb_crc8_frame_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       mode = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       out_ready = 1'b1;
    logic       sel = 1'b0;

    logic [1:0] in_valid_v;
    logic [1:0] in_ready_v, out_valid_v, out_last_v, crc_calc_v, crc_clear_v;
    logic [1:0] frame_done_v, crc_ok_v, len_err_v;
    logic [7:0] out_data_v [2];
    logic [7:0] crc_data_v [2];
    logic [7:0] frame_len_v [2];
    logic [7:0] e_crc [2];
    logic [1:0] e_busy = 2'b00;
    logic [1:0] e_calc = 2'b00;

    logic [8:0] q_out [2][$];
    logic [9:0] q_st  [2][$];
    logic [7:0] frm [$];

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    assign in_valid_v[0] = in_valid & ~sel;
    assign in_valid_v[1] = in_valid & sel;

    crc8_frame_sequencer #(.LEN_WIDTH(8), .MAX_LEN(255)) dut0 (
        .clock(clock), .reset(reset), .mode(mode), .in_data(in_data),
        .in_valid(in_valid_v[0]), .in_last(in_last), .in_ready(in_ready_v[0]),
        .out_data(out_data_v[0]), .out_valid(out_valid_v[0]), .out_last(out_last_v[0]),
        .out_ready(out_ready), .crc_data(crc_data_v[0]), .crc_calculate(crc_calc_v[0]),
        .crc_clear(crc_clear_v[0]), .crc_value(e_crc[0]), .frame_done(frame_done_v[0]),
        .crc_ok(crc_ok_v[0]), .len_err(len_err_v[0]), .frame_len(frame_len_v[0])
    );

    crc8_frame_sequencer #(.LEN_WIDTH(8), .MAX_LEN(4)) dut4 (
        .clock(clock), .reset(reset), .mode(mode), .in_data(in_data),
        .in_valid(in_valid_v[1]), .in_last(in_last), .in_ready(in_ready_v[1]),
        .out_data(out_data_v[1]), .out_valid(out_valid_v[1]), .out_last(out_last_v[1]),
        .out_ready(out_ready), .crc_data(crc_data_v[1]), .crc_calculate(crc_calc_v[1]),
        .crc_clear(crc_clear_v[1]), .crc_value(e_crc[1]), .frame_done(frame_done_v[1]),
        .crc_ok(crc_ok_v[1]), .len_err(len_err_v[1]), .frame_len(frame_len_v[1])
    );

    function automatic logic [7:0] crc_upd(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c ^ d;
        for (int i = 0; i < 8; i++) begin
            r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
        end
        return r;
    endfunction

    // Engine model: a pulse seen while idle occupies it for two edges; data sampled at the second.
    initial begin
        e_crc[0] = 8'h00;
        e_crc[1] = 8'h00;
    end
    always @(posedge clock) begin
        for (int k = 0; k < 2; k++) begin
            if (e_busy[k]) begin
                e_busy[k] <= 1'b0;
                e_crc[k]  <= e_calc[k] ? crc_upd(e_crc[k], crc_data_v[k]) : 8'h00;
            end else if (crc_calc_v[k] | crc_clear_v[k]) begin
                e_busy[k] <= 1'b1;
                e_calc[k] <= crc_calc_v[k];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_true(input string tag, input logic cond);
        chk(tag, {31'd0, cond}, 32'd1);
    endtask

    // Scoreboard: every output handshake and every frame_done pops and compares.
    always @(negedge clock) begin
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                if (out_valid_v[k] && out_ready) begin
                    chk_true("out_expected", q_out[k].size() != 0);
                    if (q_out[k].size() != 0) begin
                        chk("out_last_data", {out_last_v[k], out_data_v[k]}, q_out[k].pop_front());
                    end
                end
                if (frame_done_v[k]) begin
                    chk_true("done_expected", q_st[k].size() != 0);
                    if (q_st[k].size() != 0) begin
                        chk("status_ok_err_len", {crc_ok_v[k], len_err_v[k], frame_len_v[k]},
                            q_st[k].pop_front());
                    end
                end
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic l);
        int n;
        n = 0;
        in_data  = d;
        in_last  = l;
        in_valid = 1'b1;
        @(negedge clock);
        while (!in_ready_v[sel] && n < 200) begin
            @(negedge clock);
            n++;
        end
        chk_true("in_handshake_timeout", n < 200);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q_out[0].size() + q_out[1].size() + q_st[0].size() + q_st[1].size()) != 0
               && n < 300) begin
            @(negedge clock);
            n++;
        end
        chk_true("drain_timeout", n < 300);
        @(posedge clock);
        #1;
    endtask

    task automatic wait_out_valid();
        int n;
        n = 0;
        @(negedge clock);
        while (!out_valid_v[sel] && n < 50) begin
            @(negedge clock);
            n++;
        end
        chk_true("out_valid_timeout", n < 50);
    endtask

    // Sends frm as one input frame; expectations follow the truncation rule of the selected DUT.
    task automatic run_frame(input logic m);
        int         ml;
        int         cnt;
        logic [7:0] c;
        logic       fin, lastf, lerr;
        ml   = sel ? 4 : 255;
        cnt  = 0;
        c    = 8'h00;
        mode = m;
        for (int i = 0; i < frm.size(); i++) begin
            cnt++;
            c     = crc_upd(c, frm[i]);
            fin   = (i == frm.size() - 1);
            lastf = fin | (cnt == ml);
            lerr  = ~fin & (cnt == ml);
            q_out[sel].push_back({lastf & m, frm[i]});
            if (lastf) begin
                if (!m) q_out[sel].push_back({1'b1, c});
                q_st[sel].push_back({(m ? (c == 8'h00) : 1'b1), lerr, 8'(cnt)});
                cnt = 0;
                c   = 8'h00;
            end
            send(frm[i], fin);
        end
        drain();
    endtask

    initial begin
        logic [7:0] bp_crc;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_in_ready", in_ready_v[0], 1'b0);
        chk("rst_out_valid", out_valid_v[0], 1'b0);
        chk("rst_out_last", out_last_v[0], 1'b0);
        chk("rst_out_data", out_data_v[0], 8'h00);
        chk("rst_crc_data", crc_data_v[0], 8'h00);
        chk("rst_crc_calc", crc_calc_v[0], 1'b0);
        chk("rst_crc_clear", crc_clear_v[0], 1'b1);
        chk("rst_frame_done", frame_done_v[0], 1'b0);
        chk("rst_ok_err_len", {crc_ok_v[0], len_err_v[0], frame_len_v[0]}, 10'd0);
        chk("rst_dut4_clear_ready", {crc_clear_v[1], in_ready_v[1]}, 2'b10);
        @(posedge clock);
        #1 reset = 1'b1;

        // Generate mode: single byte and the CRC-8 check string.
        frm = '{8'h01};
        run_frame(1'b0);
        frm = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        run_frame(1'b0);

        // Check mode: good and bad residue.
        frm = '{8'h01, 8'h07};
        run_frame(1'b1);
        frm = '{8'h01, 8'h08};
        run_frame(1'b1);

        // Backpressure on both EMIT and APPEND.
        mode      = 1'b0;
        out_ready = 1'b0;
        bp_crc    = crc_upd(8'h00, 8'h5A);
        q_out[0].push_back({1'b0, 8'h5A});
        q_out[0].push_back({1'b1, bp_crc});
        q_st[0].push_back({1'b1, 1'b0, 8'd1});
        send(8'h5A, 1'b1);
        wait_out_valid();
        repeat (5) begin
            @(negedge clock);
            chk("bp_emit_valid_last_data", {out_valid_v[0], out_last_v[0], out_data_v[0]},
                {1'b1, 1'b0, 8'h5A});
            chk("bp_emit_in_ready", in_ready_v[0], 1'b0);
        end
        @(posedge clock);
        #1 out_ready = 1'b1;
        @(posedge clock);
        #1 out_ready = 1'b0;
        repeat (5) begin
            @(negedge clock);
            chk("bp_append_valid_last_data", {out_valid_v[0], out_last_v[0], out_data_v[0]},
                {1'b1, 1'b1, bp_crc});
            chk("bp_append_in_ready", in_ready_v[0], 1'b0);
        end
        @(posedge clock);
        #1 out_ready = 1'b1;
        drain();

        // Truncation at MAX_LEN=4: six bytes split into 4+CRC and 2+CRC.
        sel = 1'b1;
        frm = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        run_frame(1'b0);
        sel = 1'b0;

        // Reset mid-frame after two bytes, then a fresh frame.
        mode = 1'b0;
        q_out[0].push_back({1'b0, 8'hAA});
        q_out[0].push_back({1'b0, 8'hBB});
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b0);
        drain();
        @(negedge clock);
        chk("pre_reset_in_ready", in_ready_v[0], 1'b1);
        @(posedge clock);
        #1 reset = 1'b0;
        @(posedge clock);
        #1 reset = 1'b1;
        @(negedge clock);
        chk("mid_rst_clear_ready_valid", {crc_clear_v[0], in_ready_v[0], out_valid_v[0]}, 3'b100);
        @(negedge clock);
        chk("post_rst1_clear_ready", {crc_clear_v[0], in_ready_v[0]}, 2'b00);
        @(negedge clock);
        chk("post_rst2_in_ready", in_ready_v[0], 1'b1);
        chk("post_rst_status_cleared", {crc_ok_v[0], len_err_v[0], frame_len_v[0]}, 10'd0);
        q_out[0].push_back({1'b0, 8'h01});
        q_out[0].push_back({1'b1, 8'h07});
        q_st[0].push_back({1'b1, 1'b0, 8'd1});
        send(8'h01, 1'b1);
        drain();

        chk("final_queues_empty", q_out[0].size() + q_out[1].size() + q_st[0].size()
            + q_st[1].size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
